// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter with a load/busy/done handshake.
// A frame is WIDTH busy cycles followed by one done cycle, sent MSB-first or LSB-first.
module piso_shifter #(
  parameter int WIDTH = 4
) (
  input  logic             c,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dirr, dirr_n;

  always_ff @(posedge c or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      Q     <= '0;
      cnt   <= '0;
      dirr  <= 1'b0;
    end else begin
      state <= state_n;
      Q     <= q_n;
      cnt   <= cnt_n;
      dirr  <= dirr_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = Q;
    cnt_n   = cnt;
    dirr_n  = dirr;
    case (state)
      SHIFT: begin
        // Zero fill means Q is empty once the last bit has left.
        q_n = dirr ? (Q >> 1) : (Q << 1);
        if (cnt == '0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      IDLE, DONE: begin
        // DONE accepts a new frame just like IDLE, giving WIDTH+1 spacing.
        if (load) begin
          state_n = SHIFT;
          q_n     = din;
          dirr_n  = dir;
          cnt_n   = LAST;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign sout = busy & (dirr ? Q[0] : Q[WIDTH-1]);

endmodule

// File: tb/tb_piso_shifter.sv
// Bench for piso_shifter: directed frames with literal expectations plus random
// traffic checked every cycle against a frame-level model.
module tb_piso_shifter;

  localparam int W = 4;

  logic         c = 1'b0;
  logic         clear;
  logic         load;
  logic [W-1:0] din;
  logic         dir;
  logic         sout, busy, done;
  logic [W-1:0] Q;

  int n_pass = 0;
  int n_total = 0;

  piso_shifter #(.WIDTH(W)) dut (
    .c(c), .clear(clear), .load(load), .din(din), .dir(dir),
    .sout(sout), .busy(busy), .done(done), .Q(Q)
  );

  always #5 c = ~c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: the accepted word, its bit order, how many bits have
  // been sent (k) and how many remain (rem).
  logic [W-1:0] m_word;
  logic         m_dir;
  int           m_k, m_rem;
  logic         m_done;

  always @(posedge c or negedge clear) begin
    if (!clear) begin
      m_word = '0; m_dir = 1'b0; m_k = 0; m_rem = 0; m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_k++;
      m_rem--;
      m_done = (m_rem == 0);
    end else begin
      m_done = 1'b0;
      if (load) begin
        m_word = din; m_dir = dir; m_k = 0; m_rem = W;
      end
    end
  end

  function automatic logic [W-1:0] exp_q();
    return m_dir ? (m_word >> m_k) : (m_word << m_k);
  endfunction

  function automatic logic exp_sout();
    if (m_rem == 0) return 1'b0;
    return m_dir ? m_word[m_k] : m_word[W-1-m_k];
  endfunction

  always @(negedge c) begin
    chk("model_busy", 32'(busy), 32'(m_rem > 0));
    chk("model_done", 32'(done), 32'(m_done));
    chk("model_sout", 32'(sout), 32'(exp_sout()));
    chk("model_q",    32'(Q),    32'(exp_q()));
  end

  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge c);
    #2;
  endtask

  task automatic expect_cycle(input string name, input logic e_sout, input logic e_busy,
                              input logic e_done);
    @(negedge c);
    chk({name, "_sout"}, 32'(sout), 32'(e_sout));
    chk({name, "_busy"}, 32'(busy), 32'(e_busy));
    chk({name, "_done"}, 32'(done), 32'(e_done));
    @(posedge c);
    #2;
  endtask

  task automatic start_frame(input logic [W-1:0] w, input logic d);
    load = 1'b1; din = w; dir = d;
    tick();
    load = 1'b0;
  endtask

  initial begin
    clear = 1'b0; load = 1'b1; din = 4'b1111; dir = 1'b0;
    #1;
    chk("reset_q_async", 32'(Q), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge c);
      chk("reset_q", 32'(Q), 32'h0);
      chk("reset_out", {29'h0, sout, busy, done}, 32'h0);
    end
    tick();
    load = 1'b0;
    clear = 1'b1;
    expect_cycle("idle_after_rel", 1'b0, 1'b0, 1'b0);
    expect_cycle("idle_after_rel", 1'b0, 1'b0, 1'b0);

    // MSB-first 1011
    start_frame(4'b1011, 1'b0);
    expect_cycle("msb_b1", 1'b1, 1'b1, 1'b0);
    expect_cycle("msb_b2", 1'b0, 1'b1, 1'b0);
    expect_cycle("msb_b3", 1'b1, 1'b1, 1'b0);
    @(negedge c);
    chk("msb_b4", 32'(sout), 32'h1);
    tick();
    @(negedge c);
    chk("msb_done_q", 32'(Q), 32'h0);
    chk("msb_done", {30'h0, busy, done}, 32'h1);
    tick();
    expect_cycle("msb_after", 1'b0, 1'b0, 1'b0);

    // LSB-first 1011
    start_frame(4'b1011, 1'b1);
    expect_cycle("lsb_b1", 1'b1, 1'b1, 1'b0);
    expect_cycle("lsb_b2", 1'b1, 1'b1, 1'b0);
    expect_cycle("lsb_b3", 1'b0, 1'b1, 1'b0);
    expect_cycle("lsb_b4", 1'b1, 1'b1, 1'b0);
    expect_cycle("lsb_done", 1'b0, 1'b0, 1'b1);

    // load/din/dir during a frame are ignored
    start_frame(4'b1100, 1'b0);
    expect_cycle("ign_b1", 1'b1, 1'b1, 1'b0);
    load = 1'b1; din = 4'b0110; dir = 1'b1;
    expect_cycle("ign_b2", 1'b1, 1'b1, 1'b0);
    load = 1'b0;
    expect_cycle("ign_b3", 1'b0, 1'b1, 1'b0);
    expect_cycle("ign_b4", 1'b0, 1'b1, 1'b0);
    expect_cycle("ign_done", 1'b0, 1'b0, 1'b1);
    expect_cycle("ign_idle", 1'b0, 1'b0, 1'b0);

    // back-to-back with load held
    load = 1'b1; din = 4'b1001; dir = 1'b0;
    tick();
    for (int f = 0; f < 2; f++) begin
      expect_cycle("b2b_b1", 1'b1, 1'b1, 1'b0);
      expect_cycle("b2b_b2", 1'b0, 1'b1, 1'b0);
      expect_cycle("b2b_b3", 1'b0, 1'b1, 1'b0);
      expect_cycle("b2b_b4", 1'b1, 1'b1, 1'b0);
      expect_cycle("b2b_done", 1'b0, 1'b0, 1'b1);
    end
    load = 1'b0;
    repeat (6) tick();

    // abort mid-frame
    start_frame(4'b1111, 1'b0);
    expect_cycle("abort_b1", 1'b1, 1'b1, 1'b0);
    expect_cycle("abort_b2", 1'b1, 1'b1, 1'b0);
    clear = 1'b0;
    #1;
    chk("abort_q", 32'(Q), 32'h0);
    chk("abort_out", {29'h0, sout, busy, done}, 32'h0);
    tick();
    clear = 1'b1;
    expect_cycle("abort_idle", 1'b0, 1'b0, 1'b0);
    expect_cycle("abort_idle", 1'b0, 1'b0, 1'b0);
    start_frame(4'b0101, 1'b0);
    expect_cycle("post_b1", 1'b0, 1'b1, 1'b0);
    expect_cycle("post_b2", 1'b1, 1'b1, 1'b0);
    expect_cycle("post_b3", 1'b0, 1'b1, 1'b0);
    expect_cycle("post_b4", 1'b1, 1'b1, 1'b0);
    expect_cycle("post_done", 1'b0, 1'b0, 1'b1);

    // random traffic, checked by the model every cycle
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 2) == 0);
      din  = W'($urandom);
      dir  = 1'($urandom);
      clear = ($urandom_range(0, 59) != 0);
      tick();
    end
    clear = 1'b1; load = 1'b0;
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/piso_shifter.md
Name: piso_shifter

Overview:
- Parallel-in, serial-out shift register with a load/busy/done handshake.
- Sits directly downstream of the active-low preset/clear D flip-flop cell in the sequential library. It is built on a register bank of those flip-flops plus a small bit counter and a control FSM.
- Serialises a WIDTH-bit word onto one output, MSB-first or LSB-first.
- Serves as the transmit stage for later serial-link exercises.

Parameters:
- WIDTH, 4, number of bits per frame (legal range 1..16).

Ports:
- c  input  1  clock; all state updates on the rising edge.
- clear  input  1  asynchronous active-low reset; 0 forces reset state immediately, regardless of c.
- load  input  1  start request; sampled on the rising edge of c.
- din  input  WIDTH  parallel word; captured on an accepted load.
- dir  input  1  bit order, captured on an accepted load: 0 = MSB-first, 1 = LSB-first.
- sout  output  1  serial data bit.
- busy  output  1  high while a frame is being shifted out.
- done  output  1  one-cycle pulse after the last bit of a frame.
- Q  output  WIDTH  current shift register contents, for observation.

Behaviour:
- Reset: one clock c; reset is asynchronous and active-low (clear). While clear=0:
  - Q=0, sout=0, busy=0, done=0.
  - Internal count=0, latched dir=0, state=IDLE.
  - Release is synchronous to the next rising edge. There is no glitch on outputs at release.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - If load=1 at an edge: Q<=din, dirr<=dir, count<=WIDTH-1, busy<=1, go to SHIFT. Otherwise hold.
- SHIFT, at each edge:
  - MSB-first: Q<=Q<<1, filling 0.
  - LSB-first: Q<=Q>>1, filling 0.
  - If count==0 at that edge: go to DONE, busy<=0, done<=1. Otherwise count<=count-1.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge: done<=0. If load=1, accept a new frame exactly as in IDLE and go to SHIFT. Otherwise go to IDLE.
- sout is combinational:
  - busy=1: Q[WIDTH-1] if dirr=0, Q[0] if dirr=1.
  - busy=0: sout=0.
- Latency: first bit valid in the cycle after the accepting edge. Each bit is held exactly one cycle.
- A frame occupies exactly WIDTH busy cycles, followed by one done cycle.
- Minimum frame spacing is WIDTH+1 cycles; a load held continuously yields that spacing.
- load during SHIFT is ignored. din and dir changes during SHIFT have no effect.
- WIDTH=1: count starts at 0; one busy cycle, then done.
- After a completed frame Q=0 (all bits shifted out).
- clear=0 mid-frame aborts immediately: all outputs 0, no done pulse. After release, the block waits in IDLE for a new load.
- No X propagation: every register has a defined reset value.

Test Plan (WIDTH=4):
- Reset: clear=0 while toggling c, load=1, din=1111 -> Q=0000, busy=0, done=0, sout=0 throughout. After release with load=0: remains idle.
- MSB-first: din=1011, dir=0, one-cycle load -> sout=1,0,1,1 on cycles 1-4 with busy=1; cycle 5: done=1, busy=0, Q=0000; cycle 6: done=0.
- LSB-first: din=1011, dir=1, load -> sout=1,1,0,1 on cycles 1-4; done pulse on cycle 5.
- Ignore during busy: start din=1100, dir=0. In cycle 2 drive load=1, din=0110, dir=1 -> sout continues 1,1,0,0; single done pulse; no second frame.
- Back-to-back: load held high with din=1001, dir=0 -> frames of sout 1,0,0,1 repeat every 5 cycles. The done cycle has busy=0 and sout=0 between frames.
- Abort: start din=1111. After 2 bits, pull clear=0 mid-cycle -> Q, busy, sout drop to 0 without waiting for an edge; no done. Release, then load din=0101 -> clean frame 0,1,0,1.
